// File: rtl/mips_mc_core_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcodes,
// funct codes and the legal-encoding check used by DECODE.
package mips_mc_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // True when op/funct is one of the implemented instructions.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_SLL) || (fn == FN_JR) || (fn == FN_ADDU) || (fn == FN_SUBU) ||
                       (fn == FN_AND) || (fn == FN_OR) || (fn == FN_SLT);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. Register $0 is hard-wired to zero and ignores writes.
module mips_mc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  import mips_mc_core_pkg::*;

  logic [31:0] regs [32];

  assign regs[0] = '0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] q_reg;
      // Each register loads only when the write port addresses it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_reg <= '0;
        else if (we && (wa == 5'(gi))) q_reg <= wd;
      end
      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-I subset core. Each instruction walks FETCH/DECODE/EXEC
// and optionally MEM/WB over one shared req/ack memory port, so memory may
// insert any number of wait states. All memory-port outputs are registered
// and held from request rise through the acknowledged cycle.
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_o,
  output logic              retire,
  output logic              illegal
);
  import mips_mc_core_pkg::*;

  state_t            state_reg;
  logic [31:0]       pc_reg, ir_reg, a_reg, b_reg, alu_reg, mdr_reg, wdata_reg;
  logic              req_reg, we_reg, retire_reg, illegal_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Instruction fields.
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] simm, zimm;
  assign op    = ir_reg[31:26];
  assign rs    = ir_reg[25:21];
  assign rt    = ir_reg[20:16];
  assign rd    = ir_reg[15:11];
  assign shamt = ir_reg[10:6];
  assign fn    = ir_reg[5:0];
  assign imm   = ir_reg[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};

  // Memory addresses drop bits above ADDR_W and are always word aligned.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] v);
    return {v[ADDR_W-1:2], 2'b00};
  endfunction

  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;

  mips_mc_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  logic [31:0] alu_res, exec_pc, eff_addr;
  logic        is_ctrl, is_mem;
  assign eff_addr = a_reg + simm;

  // EXEC datapath: ALU result, next PC for control transfers, instruction class.
  always_comb begin
    alu_res = '0;
    exec_pc = pc_reg;
    is_ctrl = 1'b0;
    is_mem  = (op == OP_LW) || (op == OP_SW);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: alu_res = a_reg + b_reg;
          FN_SUBU: alu_res = a_reg - b_reg;
          FN_AND:  alu_res = a_reg & b_reg;
          FN_OR:   alu_res = a_reg | b_reg;
          FN_SLT:  alu_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
          FN_SLL:  alu_res = b_reg << shamt;
          FN_JR:   begin is_ctrl = 1'b1; exec_pc = a_reg; end
          default: alu_res = '0;
        endcase
      end
      OP_ADDIU: alu_res = a_reg + simm;
      OP_ORI:   alu_res = a_reg | zimm;
      OP_LUI:   alu_res = {imm, 16'h0000};
      OP_BEQ:   begin is_ctrl = 1'b1; if (a_reg == b_reg) exec_pc = pc_reg + (simm << 2); end
      OP_BNE:   begin is_ctrl = 1'b1; if (a_reg != b_reg) exec_pc = pc_reg + (simm << 2); end
      OP_J, OP_JAL: begin is_ctrl = 1'b1; exec_pc = {pc_reg[31:28], ir_reg[25:0], 2'b00}; end
      default: alu_res = '0;
    endcase
  end

  // Register write: jal links in EXEC (PC already advanced), everything else writes in WB.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = (op == OP_RTYPE) ? rd : rt;
    rf_wd = (op == OP_LW) ? mdr_reg : alu_reg;
    if (state_reg == S_EXEC && op == OP_JAL) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = pc_reg;
    end else if (state_reg == S_WB) begin
      rf_we = 1'b1;
    end
  end

  // Control FSM with registered memory-port, retire and illegal outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_reg     <= '0;
      mdr_reg     <= '0;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (req_reg && mem_ack) begin
            ir_reg    <= mem_rdata;
            pc_reg    <= pc_reg + 32'd4;
            req_reg   <= 1'b0;
            state_reg <= S_DECODE;
          end else if (!req_reg) begin
            // Only reached right after reset; later fetches are requested on entry.
            req_reg  <= 1'b1;
            we_reg   <= 1'b0;
            addr_reg <= word_addr(pc_reg);
          end
        end
        S_DECODE: begin
          a_reg <= rf_rd1;
          b_reg <= rf_rd2;
          if (!is_legal(op, fn)) begin
            illegal_reg <= 1'b1;
            state_reg   <= S_HALT;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ctrl) begin
            pc_reg     <= exec_pc;
            retire_reg <= 1'b1;
            req_reg    <= 1'b1;
            we_reg     <= 1'b0;
            addr_reg   <= word_addr(exec_pc);
            state_reg  <= S_FETCH;
          end else if (is_mem) begin
            alu_reg   <= eff_addr;
            req_reg   <= 1'b1;
            we_reg    <= (op == OP_SW);
            addr_reg  <= word_addr(eff_addr);
            wdata_reg <= b_reg;
            state_reg <= S_MEM;
          end else begin
            alu_reg   <= alu_res;
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (req_reg && mem_ack) begin
            we_reg <= 1'b0;
            if (op == OP_SW) begin
              retire_reg <= 1'b1;
              addr_reg   <= word_addr(pc_reg);
              state_reg  <= S_FETCH;
            end else begin
              mdr_reg   <= mem_rdata;
              req_reg   <= 1'b0;
              state_reg <= S_WB;
            end
          end
        end
        S_WB: begin
          retire_reg <= 1'b1;
          req_reg    <= 1'b1;
          we_reg     <= 1'b0;
          addr_reg   <= word_addr(pc_reg);
          state_reg  <= S_FETCH;
        end
        S_HALT:  req_reg <= 1'b0;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign pc_o      = pc_reg;
  assign retire    = retire_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: an ISA-level interpreter predicts every memory
// transfer, retire PC and instruction latency; a memory responder inserts
// fixed or random wait states and checks port stability while waiting.
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ack, retire, illegal;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, pc_o;

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(32'h0000_3000), .ADDR_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc_o      (pc_o),
    .retire    (retire),
    .illegal   (illegal)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int sh, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] o, input int s, input int t, input logic [15:0] im);
    return {o, 5'(s), 5'(t), im};
  endfunction

  // Physical memory seen by the DUT and the model's private copy.
  logic [31:0] pmem [1024];
  logic [31:0] mmem [1024];
  logic [31:0] mregs [32];
  logic [31:0] mpc;

  // Expectations for the instruction currently in flight.
  logic [11:0] e_fetch, e_daddr;
  logic [31:0] e_wdata;
  logic        e_has_data, e_we, e_illegal;
  int          e_base;

  int  active = 0, wait_mode = 0, cyc = 0, xfer_idx = 0, halt_cyc = 0;
  int  retire_cnt = 0, last_ret = 0, have_prev = 0, waits_acc = 0, st_n = 0;
  int  ret_cyc [64];
  logic [11:0] st_addr [16];
  logic [31:0] st_data [16];

  task automatic mwr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mregs[r] = v;
  endtask

  // Execute one instruction at the model PC and record what the DUT must do for it.
  task automatic model_step();
    logic [31:0] ir, a, b, si, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] im;
    ir = mmem[mpc[11:2]];
    e_fetch = {mpc[11:2], 2'b00};
    e_has_data = 0; e_we = 0; e_illegal = 0; e_base = 4; e_daddr = '0; e_wdata = '0;
    op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; sh = ir[10:6];
    fn = ir[5:0]; im = ir[15:0];
    a = mregs[rs]; b = mregs[rt]; si = {{16{im[15]}}, im};
    mpc = mpc + 32'd4;
    halt_cyc = 0;
    case (op)
      6'h00: case (fn)
        6'h21: mwr(rd, a + b);
        6'h23: mwr(rd, a - b);
        6'h24: mwr(rd, a & b);
        6'h25: mwr(rd, a | b);
        6'h2a: mwr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: mwr(rd, b << sh);
        6'h08: begin mpc = a; e_base = 3; end
        default: e_illegal = 1;
      endcase
      6'h09: mwr(rt, a + si);
      6'h0d: mwr(rt, a | {16'h0, im});
      6'h0f: mwr(rt, {im, 16'h0});
      6'h23: begin
        ea = a + si; e_has_data = 1; e_daddr = {ea[11:2], 2'b00}; e_base = 5;
        mwr(rt, mmem[ea[11:2]]);
      end
      6'h2b: begin
        ea = a + si; e_has_data = 1; e_we = 1; e_daddr = {ea[11:2], 2'b00}; e_wdata = b;
        mmem[ea[11:2]] = b;
      end
      6'h04: begin e_base = 3; if (a == b) mpc = mpc + (si << 2); end
      6'h05: begin e_base = 3; if (a != b) mpc = mpc + (si << 2); end
      6'h02: begin e_base = 3; mpc = {mpc[31:28], ir[25:0], 2'b00}; end
      6'h03: begin e_base = 3; mwr(5'd31, mpc); mpc = {mpc[31:28], ir[25:0], 2'b00}; end
      default: e_illegal = 1;
    endcase
  endtask

  // Memory responder and per-cycle comparison against the model.
  initial begin
    int          waits_left;
    logic        pending;
    logic        cap_we;
    logic [11:0] cap_addr;
    logic [31:0] cap_wd;
    pending = 0; waits_left = 0; cap_we = 0; cap_addr = '0; cap_wd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (active == 0 || reset == 1'b0) begin
        pending = 0;
        mem_ack = 1'b0;
      end else begin
        if (retire) begin
          chk("unexpected_retire", {31'b0, e_illegal}, 32'd0);
          chk("retire_xfers", xfer_idx, 1 + e_has_data);
          chk("retire_pc", pc_o, mpc);
          if (have_prev != 0) chk("latency", cyc - last_ret, e_base + waits_acc);
          if (retire_cnt < 64) ret_cyc[retire_cnt] = cyc;
          retire_cnt++;
          last_ret = cyc; have_prev = 1; waits_acc = 0;
          model_step();
          xfer_idx = 0;
        end
        if (e_illegal && xfer_idx > 0) begin
          halt_cyc++;
          if (halt_cyc >= 2) begin
            chk("halt_illegal", {31'b0, illegal}, 32'd1);
            chk("halt_req", {31'b0, mem_req}, 32'd0);
          end
        end
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
          if (!pending) begin
            pending = 1; cap_we = mem_we; cap_addr = mem_addr; cap_wd = mem_wdata;
            case (wait_mode)
              1: waits_left = 3;
              2: waits_left = $urandom_range(0, 3);
              3: waits_left = 5;
              default: waits_left = 0;
            endcase
          end else begin
            chk("hold_we", {31'b0, mem_we}, {31'b0, cap_we});
            chk("hold_addr", {20'b0, mem_addr}, {20'b0, cap_addr});
            chk("hold_wdata", mem_wdata, cap_wd);
          end
          if (waits_left == 0) begin
            mem_ack = 1'b1;
            pending = 0;
            if (xfer_idx == 0) begin
              chk("fetch_addr", {20'b0, mem_addr}, {20'b0, e_fetch});
              chk("fetch_we", {31'b0, mem_we}, 32'd0);
            end else if (xfer_idx == 1 && e_has_data) begin
              chk("data_addr", {20'b0, mem_addr}, {20'b0, e_daddr});
              chk("data_we", {31'b0, mem_we}, {31'b0, e_we});
              if (e_we) chk("data_wdata", mem_wdata, e_wdata);
            end else begin
              chk("extra_xfer", xfer_idx, 32'hFFFF_FFFF);
            end
            xfer_idx++;
            if (mem_we) begin
              pmem[mem_addr[11:2]] = mem_wdata;
              if (st_n < 16) begin st_addr[st_n] = mem_addr; st_data[st_n] = mem_wdata; end
              st_n++;
            end else begin
              mem_rdata = pmem[mem_addr[11:2]];
            end
            $display("xfer t=%0t we=%0d addr=%h data=%h pc=%h", $time, mem_we, mem_addr,
                     mem_we ? mem_wdata : mem_rdata, pc_o);
          end else begin
            waits_left--;
            waits_acc++;
          end
        end else if (wait_mode == 2) begin
          mem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Hold reset for three cycles, checking reset state, then release and see the first fetch.
  task automatic start_run(input int mode);
    int n;
    active = 0;
    reset = 1'b0;
    wait_mode = mode;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_retire", {31'b0, retire}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_pc", pc_o, 32'h0000_3000);
    end
    for (int i = 0; i < 1024; i++) mmem[i] = pmem[i];
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = 32'h0000_3000;
    model_step();
    xfer_idx = 0; retire_cnt = 0; st_n = 0; have_prev = 0; waits_acc = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    active = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 5);
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", {20'b0, mem_addr}, 32'h000);
    chk("first_pc", pc_o, 32'h0000_3000);
    chk("first_illegal", {31'b0, illegal}, 32'd0);
  endtask

  task automatic wait_retires(input int n, input int budget, input string name);
    int c = 0;
    while (retire_cnt < n && c < budget) begin @(posedge clk); c++; end
    chk(name, retire_cnt, n);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) pmem[i] = '0;
    pmem[0]  = enc_i(6'h0d, 0, 1, 16'h1234);      // ori  $1,$0,0x1234
    pmem[1]  = enc_i(6'h0f, 0, 2, 16'hABCD);      // lui  $2,0xABCD
    pmem[2]  = enc_r(1, 2, 3, 0, 6'h21);          // addu $3,$1,$2
    pmem[3]  = enc_i(6'h2b, 0, 3, 16'h0000);      // sw   $3,0($0)
    pmem[4]  = enc_i(6'h23, 0, 4, 16'h0000);      // lw   $4,0($0)
    pmem[5]  = 32'h1400_0005;                     // bne  $0,$0,+5
    pmem[6]  = 32'h0C00_0C10;                     // jal  0x3040
    pmem[7]  = enc_i(6'h2b, 0, 31, 16'h0008);     // sw   $31,8($0)
    pmem[8]  = enc_i(6'h09, 0, 5, 16'hFFFF);      // addiu $5,$0,-1
    pmem[9]  = enc_r(5, 5, 6, 0, 6'h21);          // addu $6,$5,$5
    pmem[10] = enc_r(5, 5, 0, 0, 6'h21);          // addu $0,$5,$5
    pmem[11] = enc_i(6'h2b, 0, 6, 16'h000C);      // sw   $6,12($0)
    pmem[12] = enc_i(6'h2b, 0, 0, 16'h0010);      // sw   $0,16($0)
    pmem[13] = enc_i(6'h2b, 0, 4, 16'h0014);      // sw   $4,20($0)
    pmem[14] = 32'h1000_FFFF;                     // beq  $0,$0,-1
    pmem[16] = enc_r(0, 1, 8, 4, 6'h00);          // sll  $8,$1,4
    pmem[17] = 32'h03E0_0008;                     // jr   $31
  endtask

  task automatic gen_random_prog(output logic [31:0] loop_pc);
    int n;
    n = 120;
    for (int i = 0; i < 1024; i++) pmem[i] = (i >= 512) ? $urandom : 32'h0;
    for (int i = 0; i < n; i++) begin
      int k, d, s, t, off;
      logic [15:0] im;
      k = $urandom_range(0, 14);
      d = $urandom_range(0, 15); s = $urandom_range(0, 15); t = $urandom_range(0, 15);
      im = 16'($urandom);
      off = $urandom_range(0, 3);
      if (i + 1 + off > n) off = n - 1 - i;
      case (k)
        0:  pmem[i] = enc_r(s, t, d, 0, 6'h21);
        1:  pmem[i] = enc_r(s, t, d, 0, 6'h23);
        2:  pmem[i] = enc_r(s, t, d, 0, 6'h24);
        3:  pmem[i] = enc_r(s, t, d, 0, 6'h25);
        4:  pmem[i] = enc_r(s, t, d, 0, 6'h2a);
        5:  pmem[i] = enc_r(0, t, d, $urandom_range(0, 31), 6'h00);
        6:  pmem[i] = enc_i(6'h09, s, d, im);
        7:  pmem[i] = enc_i(6'h0d, s, d, im);
        8:  pmem[i] = enc_i(6'h0f, 0, d, im);
        9:  pmem[i] = enc_i(6'h23, 0, d, 16'(32'h800 + 4 * $urandom_range(0, 511)));
        10: pmem[i] = enc_i(6'h2b, 0, t, 16'(32'h800 + 4 * $urandom_range(0, 511)));
        11: pmem[i] = enc_i(6'h04, s, t, 16'(off));
        12: pmem[i] = enc_i(6'h05, s, t, 16'(off));
        13: pmem[i] = {6'h02, 26'((32'h3000 >> 2) + i + 1 + off)};
        default: pmem[i] = {6'h03, 26'((32'h3000 >> 2) + i + 1 + off)};
      endcase
    end
    for (int r = 1; r < 16; r++) pmem[n + r - 1] = enc_i(6'h2b, 0, r, 16'(32'h800 + 4 * r));
    pmem[n + 15] = 32'h1000_FFFF;
    loop_pc = 32'h3000 + 32'(4 * (n + 15));
  endtask

  initial begin
    int lat0 [4];
    int lat3 [4];
    logic [31:0] loop_pc;
    int c;
    lat0 = '{4, 4, 4, 5};
    lat3 = '{7, 7, 10, 11};

    // Directed program with zero and with three wait states per transfer.
    for (int mode = 0; mode < 2; mode++) begin
      load_directed();
      start_run(mode);
      wait_retires(22, 3000, "directed_timeout");
      for (int i = 0; i < 4; i++)
        chk("lat_pin", ret_cyc[i + 1] - ret_cyc[i], (mode == 0) ? lat0[i] : lat3[i]);
      chk("loop_spacing", ret_cyc[21] - ret_cyc[20], (mode == 0) ? 3 : 6);
      chk("loop_pc", pc_o, 32'h0000_3038);
      chk("store_count", st_n, 5);
      chk("st0_addr", {20'b0, st_addr[0]}, 32'h000);
      chk("st0_data", st_data[0], 32'hABCD_1234);
      chk("st1_link", st_data[1], 32'h0000_301C);
      chk("st2_wrap", st_data[2], 32'hFFFF_FFFE);
      chk("st3_zero", st_data[3], 32'h0000_0000);
      chk("st4_lw", st_data[4], 32'hABCD_1234);
    end

    // Randomized programs with random wait states and stray acks.
    for (int run = 0; run < 3; run++) begin
      gen_random_prog(loop_pc);
      start_run(2);
      c = 0;
      while (mpc != loop_pc && c < 20000) begin @(posedge clk); c++; end
      chk("rand_reach_loop", mpc, loop_pc);
      wait_retires(retire_cnt + 3, 200, "rand_tail");
    end

    // Illegal opcode halts the core.
    for (int i = 0; i < 1024; i++) pmem[i] = '0;
    pmem[0] = enc_i(6'h0d, 0, 1, 16'h0005);
    pmem[1] = 32'hFC00_0000;
    start_run(0);
    wait_retires(1, 100, "pre_illegal");
    repeat (12) @(negedge clk);
    chk("illegal_set", {31'b0, illegal}, 32'd1);
    chk("illegal_noreq", {31'b0, mem_req}, 32'd0);
    chk("illegal_pc", pc_o, 32'h0000_3008);
    chk("illegal_retires", retire_cnt, 1);

    // Reset asserted while a load waits in MEM.
    for (int i = 0; i < 1024; i++) pmem[i] = '0;
    pmem[0] = enc_i(6'h23, 0, 2, 16'h0100);
    start_run(3);
    c = 0;
    while (!(mem_req && mem_addr == 12'h100) && c < 60) begin @(negedge clk); c++; end
    chk("mem_wait_seen", {20'b0, mem_addr}, 32'h100);
    repeat (2) @(negedge clk);
    #1;
    active = 0;
    reset = 1'b0;
    #1;
    chk("async_req_drop", {31'b0, mem_req}, 32'd0);
    chk("async_pc", pc_o, 32'h0000_3000);
    start_run(0);
    wait_retires(2, 100, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
